pipe_hazard_ctrl: RTL and testbench

Stateful hazard controller for the 5-stage pipelined CPU. It supersedes the combinational forwarding unit. It tracks in-flight destination registers for the EX, MEM and WB stages, and from them produces per-source forwarding selects, load-use stalls and holds for multi-cycle EX operations. It also honours branch flushes and counts stall cycles. The number of source operands and the multi-cycle latency are parametrised.

---
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stateful hazard controller for a 5-stage pipeline: tracks EX/MEM/WB destination
// records and produces forwarding selects, load-use stalls and multi-cycle EX holds.
module pipe_hazard_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int NUM_SRC   = 2,
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_use_i,
  input  logic [ADDR_W-1:0]         id_rd_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_memread_i,
  input  logic                      id_multi_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic                      ex_hold_o,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam int HOLD_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
  // With MULTI_LAT=1 the load value is 0, so a multi op never starts a hold.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MULTI_LAT - 1);

  typedef struct packed {
    logic                            valid;
    logic                            regwrite;
    logic                            memread;
    logic [ADDR_W-1:0]               rd;
    logic [NUM_SRC-1:0][ADDR_W-1:0]  rs;
    logic [NUM_SRC-1:0]              rs_use;
  } ex_rec_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [ADDR_W-1:0] rd;
  } wr_rec_t;

  ex_rec_t                        ex_q, ex_d, id_rec;
  wr_rec_t                        mem_q, mem_d, wb_q, wb_d;
  logic [HOLD_W-1:0]              hold_cnt, hold_d;
  logic [CNT_W-1:0]               stall_cnt;
  logic [NUM_SRC-1:0][ADDR_W-1:0] id_rs;
  logic                           hold_active;
  logic                           load_use;

  function automatic logic writes(input logic valid, input logic regwrite,
                                  input logic [ADDR_W-1:0] rd,
                                  input logic [ADDR_W-1:0] r);
    return valid && regwrite && (rd == r) && (r != '0);
  endfunction

  assign id_rs       = id_rs_i;
  assign hold_active = (hold_cnt != '0);
  assign stall_cnt_o = stall_cnt;

  always_comb begin
    id_rec          = '0;
    id_rec.valid    = id_valid_i;
    id_rec.regwrite = id_regwrite_i;
    id_rec.memread  = id_memread_i;
    id_rec.rd       = id_rd_i;
    id_rec.rs       = id_rs;
    id_rec.rs_use   = id_rs_use_i;
  end

  // Load-use: the ID consumer reads a register the load in EX has not produced yet.
  always_comb begin
    load_use = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_use_i[s] && writes(ex_q.valid, ex_q.regwrite, ex_q.rd, id_rs[s])) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && id_valid_i && ex_q.valid && ex_q.memread;
  end

  // Priority: flush > multi-cycle hold > load-use stall.
  always_comb begin
    ex_hold_o = hold_active && !flush_i;
    bubble_o  = load_use && !hold_active && !flush_i;
    stall_o   = ex_hold_o || bubble_o;
  end

  // Newest producer wins: MEM result beats WB data.
  always_comb begin
    fwd_sel_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (ex_q.valid && ex_q.rs_use[s]) begin
        if (writes(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs[s])) begin
          fwd_sel_o[2*s +: 2] = 2'b01;
        end else if (writes(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs[s])) begin
          fwd_sel_o[2*s +: 2] = 2'b10;
        end
      end
    end
  end

  always_comb begin
    ex_d.valid    = ex_q.valid;
    ex_d          = id_rec;
    mem_d         = '{valid: ex_q.valid, regwrite: ex_q.regwrite, rd: ex_q.rd};
    wb_d          = mem_q;
    hold_d        = '0;
    if (flush_i) begin
      ex_d  = '0;
      mem_d = '0;
    end else if (hold_active) begin
      ex_d   = ex_q;
      mem_d  = '0;
      hold_d = hold_cnt - HOLD_W'(1);
    end else if (load_use) begin
      ex_d = '0;
    end else if (id_valid_i && id_multi_i) begin
      hold_d = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      hold_cnt <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      hold_cnt <= hold_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall_o && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver pushes hand-computed per-cycle
// outputs into a queue and a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam int ADDR_W    = 5;
  localparam int NUM_SRC   = 2;
  localparam int MULTI_LAT = 4;
  localparam int CNT_W     = 2;
  localparam int W         = 3 + 2*NUM_SRC + CNT_W;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      id_valid = 1'b0;
  logic [NUM_SRC*ADDR_W-1:0] id_rs = '0;
  logic [NUM_SRC-1:0]        id_rs_use = '0;
  logic [ADDR_W-1:0]         id_rd = '0;
  logic                      id_regwrite = 1'b0;
  logic                      id_memread = 1'b0;
  logic                      id_multi = 1'b0;
  logic                      flush = 1'b0;
  logic                      stall, bubble, ex_hold;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] got_v, exp_v;
  string        cur_name;
  int           checks = 0;
  int           errors = 0;

  pipe_hazard_ctrl #(
    .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .MULTI_LAT(MULTI_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_use_i(id_rs_use), .id_rd_i(id_rd), .id_regwrite_i(id_regwrite),
    .id_memread_i(id_memread), .id_multi_i(id_multi), .flush_i(flush),
    .stall_o(stall), .bubble_o(bubble), .ex_hold_o(ex_hold),
    .fwd_sel_o(fwd_sel), .stall_cnt_o(stall_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Expected vector layout: {stall, bubble, ex_hold, fwd_sel[3:0], stall_cnt[1:0]}
  function automatic logic [W-1:0] ev(input logic st, input logic bb, input logic hd,
                                      input logic [3:0] f, input logic [1:0] c);
    return {st, bb, hd, f, c};
  endfunction

  // Driver: called at posedge+1, applies one ID slot and queues that cycle's outputs.
  task automatic drive(input string nm, input logic v, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] u, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mul, input logic fl,
                       input logic [W-1:0] e);
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_use   = u;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_multi    = mul;
    flush       = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic [W-1:0] e);
    drive(nm, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle("rst_state", ev(0, 0, 0, 4'b0000, 2'd0));
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got_v    = {stall, bubble, ex_hold, fwd_sel, stall_cnt};
      exp_v    = exp_q.pop_front();
      cur_name = name_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got stall=%b bubble=%b hold=%b fwd=%b cnt=%0d, expected stall=%b bubble=%b hold=%b fwd=%b cnt=%0d",
                 cur_name, got_v[8], got_v[7], got_v[6], got_v[5:2], got_v[1:0],
                 exp_v[8], exp_v[7], exp_v[6], exp_v[5:2], exp_v[1:0]);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    reset_dut();

    // Reset mid-hold: mul, one hold cycle, then async reset while cnt=2
    drive("rm_issue_mul", 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 1, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    idle("rm_hold1", ev(1, 0, 1, 4'b0000, 2'd0));
    exp_q.push_back(ev(0, 0, 0, 4'b0000, 2'd0));
    name_q.push_back("rm_async_rst");
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("rm_release0", ev(0, 0, 0, 4'b0000, 2'd0));
    idle("rm_release1", ev(0, 0, 0, 4'b0000, 2'd0));

    // ALU-ALU forwarding
    reset_dut();
    drive("alu_add_x5", 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("alu_sub_id", 1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("alu_sub_ex", 1, 5'd5, 5'd0, 2'b11, 5'd7, 1, 0, 0, 0, ev(0, 0, 0, 4'b0101, 2'd0));
    drive("alu_or_ex",  1, 5'd1, 5'd1, 2'b11, 5'd0, 1, 0, 0, 0, ev(0, 0, 0, 4'b0010, 2'd0));
    drive("alu_x0_prod", 1, 5'd0, 5'd0, 2'b11, 5'd8, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("alu_x0_cons", 1, 5'd8, 5'd8, 2'b01, 5'd10, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    idle("alu_use_mask", ev(0, 0, 0, 4'b0001, 2'd0));
    idle("alu_ex_empty", ev(0, 0, 0, 4'b0000, 2'd0));

    // Load-use, then a flush coinciding with a second load-use
    reset_dut();
    drive("lu_lw",      1, 5'd2, 5'd0, 2'b01, 5'd3, 1, 1, 0, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("lu_stall",   1, 5'd3, 5'd1, 2'b11, 5'd4, 1, 0, 0, 0, ev(1, 1, 0, 4'b0000, 2'd0));
    drive("lu_reissue", 1, 5'd3, 5'd1, 2'b11, 5'd4, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd1));
    idle("lu_add_ex", ev(0, 0, 0, 4'b0010, 2'd1));
    idle("lu_drain", ev(0, 0, 0, 4'b0000, 2'd1));
    drive("luf_lw",     1, 5'd2, 5'd0, 2'b01, 5'd3, 1, 1, 0, 0, ev(0, 0, 0, 4'b0000, 2'd1));
    drive("luf_flush",  1, 5'd3, 5'd1, 2'b11, 5'd4, 1, 0, 0, 1, ev(0, 0, 0, 4'b0000, 2'd1));
    idle("luf_after", ev(0, 0, 0, 4'b0000, 2'd1));

    // Multi-cycle op with a dependent consumer
    reset_dut();
    drive("mc_mul",   1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 1, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("mc_hold1", 1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 0, 0, ev(1, 0, 1, 4'b0000, 2'd0));
    drive("mc_hold2", 1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 0, 0, ev(1, 0, 1, 4'b0000, 2'd1));
    drive("mc_hold3", 1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 0, 0, ev(1, 0, 1, 4'b0000, 2'd2));
    drive("mc_adv",   1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd3));
    idle("mc_dep_fwd", ev(0, 0, 0, 4'b0001, 2'd3));
    idle("mc_drain", ev(0, 0, 0, 4'b0000, 2'd3));

    // Flush in the second hold cycle
    reset_dut();
    drive("fh_mul",   1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 1, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("fh_hold1", 1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 0, 0, ev(1, 0, 1, 4'b0000, 2'd0));
    drive("fh_flush", 1, 5'd5, 5'd0, 2'b11, 5'd6, 1, 0, 0, 1, ev(0, 0, 0, 4'b0000, 2'd1));
    drive("fh_after", 1, 5'd5, 5'd5, 2'b11, 5'd7, 1, 0, 0, 0, ev(0, 0, 0, 4'b0000, 2'd1));
    idle("fh_next_ex", ev(0, 0, 0, 4'b0000, 2'd1));

    // Back-to-back multi ops: six stall cycles saturate the 2-bit counter
    reset_dut();
    drive("sat_mul1",  1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 1, 0, ev(0, 0, 0, 4'b0000, 2'd0));
    drive("sat_h1",    1, 5'd5, 5'd0, 2'b01, 5'd6, 1, 0, 1, 0, ev(1, 0, 1, 4'b0000, 2'd0));
    drive("sat_h2",    1, 5'd5, 5'd0, 2'b01, 5'd6, 1, 0, 1, 0, ev(1, 0, 1, 4'b0000, 2'd1));
    drive("sat_h3",    1, 5'd5, 5'd0, 2'b01, 5'd6, 1, 0, 1, 0, ev(1, 0, 1, 4'b0000, 2'd2));
    drive("sat_mul2",  1, 5'd5, 5'd0, 2'b01, 5'd6, 1, 0, 1, 0, ev(0, 0, 0, 4'b0000, 2'd3));
    idle("sat_h4", ev(1, 0, 1, 4'b0001, 2'd3));
    idle("sat_h5", ev(1, 0, 1, 4'b0010, 2'd3));
    idle("sat_h6", ev(1, 0, 1, 4'b0000, 2'd3));
    idle("sat_adv", ev(0, 0, 0, 4'b0000, 2'd3));
    idle("sat_stay", ev(0, 0, 0, 4'b0000, 2'd3));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
